// File: rtl/timer0_pkg.sv
// ============================================================================
// Module   : timer0_pkg
// Brief    : Shared constants and types for the Timer/Counter0 controller.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package timer0_pkg;

    localparam logic [2:0] CS_STOP     = 3'b000;
    localparam logic [2:0] CS_DIV1     = 3'b001;
    localparam logic [2:0] CS_DIV8     = 3'b010;
    localparam logic [2:0] CS_DIV64    = 3'b011;
    localparam logic [2:0] CS_DIV256   = 3'b100;
    localparam logic [2:0] CS_DIV1024  = 3'b101;
    localparam logic [2:0] CS_EXT_FALL = 3'b110;
    localparam logic [2:0] CS_EXT_RISE = 3'b111;

    localparam int OCF0  = 1;
    localparam int TOV0  = 0;
    localparam int OCIE0 = 1;
    localparam int TOIE0 = 0;
    localparam int WGM01 = 3;
    localparam int WGM00 = 6;

    localparam logic IRQ_ID_COMP = 1'b1;
    localparam logic IRQ_ID_OVF  = 1'b0;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        REQ  = 1'b1
    } state_t;

endpackage

`default_nettype wire

// File: rtl/timer0_prescaler.sv
// ============================================================================
// Module   : timer0_prescaler
// Brief    : Free-running prescaler, T0 edge detect and clock-select decode.
//            T0 edge sources exist only when TIMER0_EXT_CLK_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module timer0_prescaler #(
    parameter int PRESCALE_W = 10
) (
    input  logic       sysClock,
    input  logic       system_reset,
    input  logic [2:0] cs,
    input  logic       t0_pin,
    output logic       tick
);
    import timer0_pkg::*;

    logic [PRESCALE_W-1:0] r_prescale;
    logic [PRESCALE_W-1:0] w_prescale_next;
    logic                  r_tick;
    logic                  w_tick_next;
    logic                  w_t0_rise;
    logic                  w_t0_fall;

    assign w_prescale_next = r_prescale + PRESCALE_W'(1);

`ifdef TIMER0_EXT_CLK_EN
    logic r_t0_q;

    always_ff @(posedge sysClock or negedge system_reset) begin
        if (!system_reset) begin
            r_t0_q <= 1'b0;
        end else begin
            r_t0_q <= t0_pin;
        end
    end

    assign w_t0_rise = t0_pin & ~r_t0_q;
    assign w_t0_fall = ~t0_pin & r_t0_q;
`else
    logic w_unused_t0;

    assign w_unused_t0 = t0_pin;
    assign w_t0_rise   = 1'b0;
    assign w_t0_fall   = 1'b0;
`endif

    // Decode on the next prescaler value so the registered tick lines up with
    // the cycle in which the low bits read all ones.
    always_comb begin
        w_tick_next = 1'b0;
        case (cs)
            CS_DIV1:     w_tick_next = 1'b1;
            CS_DIV8:     w_tick_next = &w_prescale_next[2:0];
            CS_DIV64:    w_tick_next = &w_prescale_next[5:0];
            CS_DIV256:   w_tick_next = &w_prescale_next[7:0];
            CS_DIV1024:  w_tick_next = &w_prescale_next[9:0];
            CS_EXT_FALL: w_tick_next = w_t0_fall;
            CS_EXT_RISE: w_tick_next = w_t0_rise;
            default:     w_tick_next = 1'b0;
        endcase
    end

    always_ff @(posedge sysClock or negedge system_reset) begin
        if (!system_reset) begin
            r_prescale <= '0;
            r_tick     <= 1'b0;
        end else begin
            r_prescale <= w_prescale_next;
            r_tick     <= w_tick_next;
        end
    end

    assign tick = r_tick;

endmodule

`default_nettype wire

// File: rtl/timer0_controller.sv
// ============================================================================
// Module   : timer0_controller
// Brief    : Timer/Counter0 count, compare/overflow flags and IRQ handshake.
//            Optional macro TIMER0_EXT_CLK_EN enables T0 edge clocking.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module timer0_controller #(
    parameter int PRESCALE_W = 10,
    parameter int CNT_W      = 8
) (
    input  logic       sysClock,
    input  logic       system_reset,
    input  logic [7:0] TCCR_value,
    input  logic [7:0] OCR_value,
    input  logic [7:0] TIMSK_value,
    input  logic       TCNT_wr_en,
    input  logic [7:0] TCNT_wr_data,
    input  logic       TIFR_wr_en,
    input  logic [7:0] TIFR_wr_data,
    input  logic       t0_pin,
    input  logic       global_int_en,
    input  logic       irq_ack,
    output logic [7:0] TCNT_value,
    output logic [7:0] TIFR_value,
    output logic       irq_req,
    output logic       irq_id,
    output logic       tick
);
    import timer0_pkg::*;

    localparam logic [CNT_W-1:0] C_CNT_MAX = '1;

    logic [CNT_W-1:0] r_tcnt, w_tcnt_next;
    logic             r_block, w_block_next;
    logic             r_ocf, w_ocf_next;
    logic             r_tov, w_tov_next;
    logic             r_irq_id, w_irq_id_next;
    state_t           r_state, w_state_next;

    logic w_tick, w_ctc, w_match, w_tov_set;
    logic w_ack_comp, w_ack_ovf, w_comp_pend, w_ovf_pend, w_withdraw;
    logic w_unused_bits;

    timer0_prescaler #(
        .PRESCALE_W (PRESCALE_W)
    ) u_prescaler (
        .sysClock     (sysClock),
        .system_reset (system_reset),
        .cs           (TCCR_value[2:0]),
        .t0_pin       (t0_pin),
        .tick         (w_tick)
    );

    // PWM modes (WGM00=1) fall back to normal counting.
    assign w_ctc     = TCCR_value[WGM01] & ~TCCR_value[WGM00];
    assign w_match   = w_tick & ~TCNT_wr_en & ~r_block & (r_tcnt == OCR_value);
    assign w_tov_set = w_tick & ~TCNT_wr_en & (r_tcnt == C_CNT_MAX);

    always_comb begin
        w_tcnt_next  = r_tcnt;
        w_block_next = r_block;
        if (TCNT_wr_en) begin
            w_tcnt_next  = TCNT_wr_data;
            w_block_next = 1'b1;
        end else if (w_tick) begin
            w_block_next = 1'b0;
            if (w_match && w_ctc) begin
                w_tcnt_next = '0;
            end else begin
                w_tcnt_next = r_tcnt + CNT_W'(1);
            end
        end
    end

    assign w_ack_comp = (r_state == REQ) & irq_ack & (r_irq_id == IRQ_ID_COMP);
    assign w_ack_ovf  = (r_state == REQ) & irq_ack & (r_irq_id == IRQ_ID_OVF);

    // Hardware set dominates both software write-1-clear and acknowledge.
    assign w_ocf_next = w_match |
                        (r_ocf & ~(TIFR_wr_en & TIFR_wr_data[OCF0]) & ~w_ack_comp);
    assign w_tov_next = w_tov_set |
                        (r_tov & ~(TIFR_wr_en & TIFR_wr_data[TOV0]) & ~w_ack_ovf);

    assign w_comp_pend = global_int_en & r_ocf & TIMSK_value[OCIE0];
    assign w_ovf_pend  = global_int_en & r_tov & TIMSK_value[TOIE0];

    assign w_withdraw = (r_irq_id == IRQ_ID_COMP) ?
                        (~global_int_en | ~TIMSK_value[OCIE0] | ~w_ocf_next) :
                        (~global_int_en | ~TIMSK_value[TOIE0] | ~w_tov_next);

    always_comb begin
        w_state_next  = r_state;
        w_irq_id_next = r_irq_id;
        case (r_state)
            IDLE: begin
                if (w_comp_pend || w_ovf_pend) begin
                    w_state_next  = REQ;
                    w_irq_id_next = w_comp_pend ? IRQ_ID_COMP : IRQ_ID_OVF;
                end
            end
            REQ: begin
                if (irq_ack || w_withdraw) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge sysClock or negedge system_reset) begin
        if (!system_reset) begin
            r_tcnt   <= '0;
            r_block  <= 1'b0;
            r_ocf    <= 1'b0;
            r_tov    <= 1'b0;
            r_irq_id <= 1'b0;
            r_state  <= IDLE;
        end else begin
            r_tcnt   <= w_tcnt_next;
            r_block  <= w_block_next;
            r_ocf    <= w_ocf_next;
            r_tov    <= w_tov_next;
            r_irq_id <= w_irq_id_next;
            r_state  <= w_state_next;
        end
    end

    assign w_unused_bits = ^{TCCR_value[7], TCCR_value[5:4],
                             TIMSK_value[7:2], TIFR_wr_data[7:2]};

    assign TCNT_value = r_tcnt;
    assign TIFR_value = {6'b000000, r_ocf, r_tov};
    assign irq_req    = (r_state == REQ);
    assign irq_id     = r_irq_id;
    assign tick       = w_tick;

endmodule

`default_nettype wire

// File: doc/timer0_controller.md
Name: timer0_controller

Overview:
- Sequencing controller for the 8-bit Timer/Counter0 register set: prescaler, clock select, count update, compare/overflow detection, TIFR flag management and the interrupt request handshake.
- Consumes the configuration register values (TCCR0, OCR0, TIMSK) and CPU write strobes.
- Owns TCNT0 and TIFR timer flag state.
- Presents a single arbitrated request/acknowledge interface to the interrupt unit.

Parameters:
- PRESCALE_W, 10, width of the free-running prescaler counter (supports /1024).
- CNT_W, 8, timer width; only 8 is supported.

Ports:
- sysClock  in  1  system clock; all state updates on rising edge
- system_reset  in  1  asynchronous, active-low reset
- TCCR_value  in  8  current TCCR0 (CS0[2:0]=bits 2:0, WGM01=bit3, WGM00=bit6)
- OCR_value  in  8  current OCR0
- TIMSK_value  in  8  bit1 OCIE0, bit0 TOIE0; other bits ignored
- TCNT_wr_en  in  1  CPU write strobe for TCNT0
- TCNT_wr_data  in  8  CPU write data for TCNT0
- TIFR_wr_en  in  1  CPU write strobe for TIFR
- TIFR_wr_data  in  8  write-1-to-clear data (bits 1:0 used)
- t0_pin  in  1  external T0 input, already synchronised
- global_int_en  in  1  SREG I bit
- irq_ack  in  1  interrupt unit accepts the current request
- TCNT_value  out  8  current count
- TIFR_value  out  8  bits 1:0 = OCF0, TOV0; bits 7:2 read 0
- irq_req  out  1  interrupt request
- irq_id  out  1  1 = compare match, 0 = overflow; valid while irq_req=1
- tick  out  1  one-cycle count-enable pulse (observability)

Behaviour:
- Reset (async, system_reset=0): prescaler, TCNT_value, TIFR_value, irq_req, irq_id, tick, compare-block flag, t0 edge register and FSM all go to 0/IDLE immediately.
- Prescaler:
  - Free-running, never cleared by CS changes.
  - tick is asserted in the cycle where the prescaler low bits are all ones.
  - CS 000: tick never asserted (timer stopped).
  - CS 001: tick every cycle.
  - CS 010/011/100/101: tick on the respective low 3/6/8/10 bits all ones (/8, /64, /256, /1024).
  - CS 110/111: tick in the cycle after a detected falling/rising edge of t0_pin (1-cycle latency from the edge register).
- Count update, priority highest first:
  1. TCNT_wr_en: TCNT_value <= TCNT_wr_data; the tick in that cycle is discarded; compare block is set.
  2. tick with match (TCNT_value == OCR_value, compare block clear): set OCF0. In CTC mode (WGM01=1, WGM00=0) TCNT_value <= 0; otherwise TCNT_value <= TCNT_value+1.
  3. tick without match: TCNT_value <= TCNT_value+1, wrapping FF to 00.
- Compare block: cleared at the first tick after it is set. That tick performs no match detection.
- TOV0: set when TCNT transitions FF to 00 by tick, in any mode, including CTC with OCR=FF.
- WGM00=1 (PWM modes) is unsupported and behaves as normal mode.
- Flags:
  - Hardware set and CPU write-1 clear in the same cycle: the set wins.
  - irq_ack clears the flag selected by irq_id. A simultaneous hardware set of that same flag wins.
- Interrupt FSM:
  - IDLE: if global_int_en && ((OCF0&&OCIE0) || (TOV0&&TOIE0)), go to REQ next cycle and latch irq_id. Compare has priority over overflow.
  - REQ: irq_req=1 and irq_id held stable.
    - irq_ack: clear the latched flag and go to IDLE.
    - Latched flag cleared by software, its mask bit dropped, or global_int_en=0: withdraw, go to IDLE without ack.
  - Minimum one IDLE cycle between requests.
  - irq_ack in IDLE is ignored.

Optional Feature:
- TIMER0_EXT_CLK_EN defined: CS 110/111 select T0 edges as described in Behaviour.
- Not defined: CS 110/111 behave as CS 000 (stopped). t0_pin is ignored and no edge register is synthesised; the port remains in the interface.

Decomposition:
- Package timer0_pkg:
  - CS code constants.
  - Bit positions: OCF0=1, TOV0=0, OCIE0=1, TOIE0=0, WGM01=3, WGM00=6.
  - IRQ_ID_COMP=1, IRQ_ID_OVF=0.
  - FSM state typedef {IDLE, REQ}.
- Sub-module timer0_prescaler: free counter, T0 edge detect and CS decode. Interface: sysClock, system_reset, cs[2:0], t0_pin -> tick.

Test Plan:
- CS=001, OCR=05, TIMSK=01, I=1: TCNT counts 00..FF then 00; TOV0=1 on the wrap cycle; irq_req=1 with irq_id=0 the next cycle; irq_ack clears TOV0 and drops irq_req.
- CTC, CS=010, OCR=03: tick every 8 cycles; sequence 0,1,2,3,0; OCF0 set on each 3 to 0 step; TOV0 stays 0.
- Both flags pending, both masks set: irq_id=1 first; after ack, irq_req re-asserts with irq_id=0 after one IDLE cycle.
- TCNT_wr_en with data=OCR=10 and a tick in the same cycle: TCNT=10, no increment; the next tick gives no OCF0 and TCNT=11.
- TIFR write 02 in the same cycle as a hardware compare set: OCF0 remains 1. Software clears the latched flag during REQ: irq_req withdraws next cycle without ack.
- CS=111 with TIMER0_EXT_CLK_EN, three rising edges on t0_pin: TCNT=3. Reset asserted mid-count: all outputs 0 immediately.
